// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: validates a latched sale, runs the product motor, pays greedy change and acks the vend request.
module vend_dispense_ctrl #(
  parameter int DISP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] credit,
  input  logic [7:0] price,
  input  logic       stock_empty,
  output logic       busy,
  output logic       motor,
  output logic       coin_q,
  output logic       coin_d,
  output logic       coin_n,
  output logic       coin_p,
  output logic       ack,
  output logic [1:0] status
);
  localparam int CW = DISP_CYCLES > 1 ? $clog2(DISP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, DISPENSE, CHANGE, ACK} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] cr, pr, rem, cr_n, pr_n, rem_n, src, val;
  logic [3:0] coins, coins_n, pick;
  logic [1:0] status_n;
  logic motor_n, ack_n;
  // Coins are chosen one edge ahead so each pulse is registered; a refund pays from the latched credit.
  assign src = state == CHECK ? cr : rem;
  assign pick = src >= 8'd25 ? 4'b1000 : src >= 8'd10 ? 4'b0100 : src >= 8'd5 ? 4'b0010 : src != 8'd0 ? 4'b0001 : 4'b0000;
  assign val = src >= 8'd25 ? 8'd25 : src >= 8'd10 ? 8'd10 : src >= 8'd5 ? 8'd5 : src != 8'd0 ? 8'd1 : 8'd0;
  assign {coin_q, coin_d, coin_n, coin_p} = coins;
  always_comb begin
    state_n = state;
    cr_n = cr;
    pr_n = pr;
    rem_n = rem;
    cnt_n = cnt;
    status_n = status;
    motor_n = 1'b0;
    ack_n = 1'b0;
    coins_n = 4'b0000;
    case (state)
      IDLE: if (req) begin
        state_n = CHECK;
        cr_n = credit;
        pr_n = price;
        status_n = 2'b00;
      end
      CHECK: if (stock_empty || cr < pr) begin
        state_n = CHANGE;
        status_n = stock_empty ? 2'b11 : 2'b10;
        coins_n = pick;
        rem_n = cr - val;
      end else begin
        state_n = DISPENSE;
        status_n = 2'b01;
        rem_n = cr - pr;
        cnt_n = CW'(DISP_CYCLES - 1);
        motor_n = 1'b1;
      end
      DISPENSE: if (cnt == '0) begin
        state_n = CHANGE;
        coins_n = pick;
        rem_n = rem - val;
      end else begin
        cnt_n = cnt - 1'b1;
        motor_n = 1'b1;
      end
      // A cycle with no pulse marks the end of the payout.
      CHANGE: if (coins == 4'b0000) begin
        state_n = ACK;
        ack_n = 1'b1;
      end else begin
        coins_n = pick;
        rem_n = rem - val;
      end
      ACK: if (req) ack_n = 1'b1;
           else state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cr <= '0;
      pr <= '0;
      rem <= '0;
      cnt <= '0;
      status <= '0;
      motor <= 1'b0;
      ack <= 1'b0;
      coins <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cr <= cr_n;
      pr <= pr_n;
      rem <= rem_n;
      cnt <= cnt_n;
      status <= status_n;
      motor <= motor_n;
      ack <= ack_n;
      coins <= coins_n;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: directed and randomized vends checked cycle-by-cycle against a greedy-change reference model.
module tb_vend_dispense_ctrl;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic [7:0] credit = '0;
  logic [7:0] price = '0;
  logic stock_empty = 1'b0;
  logic busy, motor, coin_q, coin_d, coin_n, coin_p, ack;
  logic [1:0] status;
  int checks = 0;
  int errors = 0;
  logic [1:0] last_status = 2'b00;

  vend_dispense_ctrl #(.DISP_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .req(req), .credit(credit), .price(price),
    .stock_empty(stock_empty), .busy(busy), .motor(motor), .coin_q(coin_q),
    .coin_d(coin_d), .coin_n(coin_n), .coin_p(coin_p), .ack(ack), .status(status)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_txn(input logic [7:0] c, input logic [7:0] p, input logic se, input int hold);
    logic [4:0] exp_q[$];
    int coin_val[4] = '{25, 10, 5, 1};
    int r;
    logic [1:0] exp_st;
    logic [4:0] e;
    exp_st = se ? 2'b11 : (c < p) ? 2'b10 : 2'b01;
    r = (exp_st == 2'b01) ? int'(c) - int'(p) : int'(c);
    if (exp_st == 2'b01) for (int i = 0; i < D; i++) exp_q.push_back(5'b10000);
    while (r > 0) begin
      for (int k = 0; k < 4; k++)
        if (r >= coin_val[k]) begin
          exp_q.push_back(5'b01000 >> k);
          r -= coin_val[k];
          break;
        end
    end
    exp_q.push_back(5'b00000);
    checks++;
    if (status !== last_status) begin
      errors++;
      $display("FAIL idle_status c=%0d p=%0d: got %b want %b", c, p, status, last_status);
    end
    credit = c;
    price = p;
    stock_empty = se;
    req = 1'b1;
    step();
    checks++;
    if ({busy, motor, coin_q, coin_d, coin_n, coin_p, ack, status} !== {1'b1, 6'b0, 2'b00}) begin
      errors++;
      $display("FAIL check_cycle c=%0d p=%0d: got %b want %b", c, p,
               {busy, motor, coin_q, coin_d, coin_n, coin_p, ack, status}, {1'b1, 6'b0, 2'b00});
    end
    credit = 8'($urandom);
    price = 8'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      stock_empty = 1'($urandom);
      e = exp_q[i];
      checks++;
      if ({busy, ack, motor, coin_q, coin_d, coin_n, coin_p} !== {2'b10, e}) begin
        errors++;
        $display("FAIL seq c=%0d p=%0d se=%0d cyc=%0d: got %b want %b", c, p, se, i,
                 {busy, ack, motor, coin_q, coin_d, coin_n, coin_p}, {2'b10, e});
      end
    end
    step();
    checks++;
    if ({busy, ack, motor, status} !== {3'b110, exp_st}) begin
      errors++;
      $display("FAIL ack_rise c=%0d p=%0d se=%0d: got %b want %b", c, p, se,
               {busy, ack, motor, status}, {3'b110, exp_st});
    end
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if ({ack, status} !== {1'b1, exp_st}) begin
        errors++;
        $display("FAIL ack_hold c=%0d p=%0d: got %b want %b", c, p, {ack, status}, {1'b1, exp_st});
      end
    end
    req = 1'b0;
    step();
    checks++;
    if ({busy, ack, status} !== {2'b00, exp_st}) begin
      errors++;
      $display("FAIL ack_fall c=%0d p=%0d: got %b want %b", c, p, {busy, ack, status}, {2'b00, exp_st});
    end
    last_status = exp_st;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req = 1'($urandom);
      credit = 8'($urandom);
      price = 8'($urandom);
      stock_empty = 1'($urandom);
      step();
    end
    checks++;
    if ({busy, motor, coin_q, coin_d, coin_n, coin_p, ack, status} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {busy, motor, coin_q, coin_d, coin_n, coin_p, ack, status});
    end
    req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, motor, ack} !== 3'b0) begin
        errors++;
        $display("FAIL reset_idle: got %b want 000", {busy, motor, ack});
      end
    end
    last_status = 2'b00;
  endtask

  task automatic test_vend_change();
    test_txn(8'd50, 8'd35, 1'b0, 5);
  endtask

  task automatic test_insufficient();
    test_txn(8'd30, 8'd35, 1'b0, 0);
  endtask

  task automatic test_sold_out();
    test_txn(8'd99, 8'd10, 1'b1, 1);
  endtask

  task automatic test_exact();
    test_txn(8'd40, 8'd40, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    credit = 8'd50;
    price = 8'd35;
    stock_empty = 1'b0;
    req = 1'b1;
    step();
    step();
    step();
    step();
    checks++;
    if (motor !== 1'b1) begin
      errors++;
      $display("FAIL mid_motor3: got %b want 1", motor);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 1'b0;
    checks++;
    if ({busy, motor, coin_q, coin_d, coin_n, coin_p, ack, status} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b want 0", {busy, motor, coin_q, coin_d, coin_n, coin_p, ack, status});
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({busy, motor, coin_q, coin_d, coin_n, coin_p, ack} !== 7'b0) begin
        errors++;
        $display("FAIL mid_quiet cyc=%0d: got %b want 0", i, {busy, motor, coin_q, coin_d, coin_n, coin_p, ack});
      end
    end
    last_status = 2'b00;
    test_txn(8'd10, 8'd5, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [7:0] c, p;
    for (int n = 0; n < 30; n++) begin
      c = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? c : 8'($urandom);
      test_txn(c, p, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    test_txn(8'd0, 8'd0, 1'b0, 0);
    test_txn(8'd0, 8'd1, 1'b0, 0);
    test_txn(8'd255, 8'd0, 1'b0, 0);
    test_txn(8'd255, 8'd255, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_vend_change();
    test_insufficient();
    test_sold_out();
    test_exact();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_dispense_ctrl.md
# vend_dispense_ctrl

Dispense-and-change controller for the digital vending machine: the responder end of the vend request issued by the coin-accepting FSM once credit has been checked. It latches credit and price and validates the sale against stock. It then drives the product motor for a fixed time, pays out change (or a full refund) as single-coin pulses, and closes the transaction with a 4-phase req/ack handshake.

## Interface
Parameters:
- DISP_CYCLES, 4, number of cycles motor is held high per vend (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  vend request from the accepting FSM; 4-phase with ack
- credit  input  8  inserted credit in cents, unsigned; sampled when req is accepted
- price  input  8  item price in cents, unsigned; sampled with credit
- stock_empty  input  1  selected slot empty; sampled in CHECK only
- busy  output  1  high in every state except IDLE
- motor  output  1  product motor drive
- coin_q / coin_d / coin_n / coin_p  output  1 each  one-cycle eject pulse for 25/10/5/1 cent coin
- ack  output  1  transaction complete; held until req low
- status  output  2  00 none, 01 vended, 10 insufficient credit, 11 sold out

## Operation
- All outputs registered (Moore). States: IDLE, CHECK, DISPENSE, CHANGE, ACK.
- IDLE: if req=1, latch credit/price into internal regs and go to CHECK. status holds its last value until this accept, then clears to 00.
- CHECK (1 cycle): conditions evaluated in priority order:
  - stock_empty=1: remaining=credit, status=11, go to CHANGE.
  - credit<price (unsigned): remaining=credit, status=10, go to CHANGE.
  - otherwise: remaining=credit-price (8-bit, no underflow possible), status=01, go to DISPENSE.
- DISPENSE: motor=1 for exactly DISP_CYCLES cycles via down-counter, then go to CHANGE.
- CHANGE: one action per cycle, greedy:
  - remaining>=25: pulse coin_q, subtract 25.
  - else >=10: pulse coin_d, subtract 10.
  - else >=5: pulse coin_n, subtract 5.
  - else >=1: pulse coin_p, subtract 1.
  - remaining==0: no pulse, go to ACK.
  - At most one coin output high in any cycle.
- ACK: ack=1, status stable. Stay while req=1; on req=0 go to IDLE with ack=0 next cycle.
- req changes while busy (outside ACK) are ignored. Latched credit/price are not affected by input changes after accept.
- credit==price: dispense, then one CHANGE cycle with no pulse, then ACK.
- Reset (any state, mid-operation included): next edge gives state IDLE and busy, motor, all coin pulses, ack=0, status=00, and internal regs 0. An aborted vend produces no further motor or coin activity.

## Timing
- Edge E0 samples req=1 in IDLE. CHECK occupies cycle after E0, with busy=1 from E0.
- Vend path: motor high for DISP_CYCLES cycles starting at E1. Coin pulses follow on consecutive cycles, then one zero cycle, then ack rises.
- Refund path: coin pulses start at E1, with no motor.
- Latency from req accept to ack: 1 + (DISP_CYCLES if vended) + number of coins + 1 cycles.
- ack falls one cycle after req is sampled low. The earliest next accept is the edge after that, from IDLE.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs. Required: all outputs 0, status=00, busy=0. Release with req=0 and the block stays IDLE.
- Vend with change: credit=50, price=35, stock_empty=0, DISP_CYCLES=4. Required: motor high exactly 4 cycles, then coin_d one pulse, then coin_n one pulse, then ack=1 with status=01. Holding req high 5 extra cycles keeps ack high; ack drops 1 cycle after req=0.
- Insufficient credit: credit=30, price=35. Required: motor never high, coin_q then coin_n, ack with status=10.
- Sold out: stock_empty=1, credit=99. Required: no motor; pulses Q,Q,Q,D,D,P,P,P,P (9 cycles, total 99); status=11.
- Exact credit: credit=price=40. Required: motor 4 cycles, zero coin pulses, ack at 6th cycle after accept, status=01.
- Reset mid-vend: assert rst during the 3rd motor cycle. Required: motor=0 after that edge, no coin pulses, ack=0, status=00. A following credit=10, price=5 transaction completes normally with one coin_n pulse.
